// File: rtl/data_bus_bridge_pkg.sv
// Shared constants, UART state encoding and byte-lane helper for the data bus bridge.
package data_bus_bridge_pkg;

  localparam logic [3:0] REGION_RAM = 4'h0;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TCOUNT = 3'd2;
  localparam logic [2:0] OFF_TCMP   = 3'd3;
  localparam logic [2:0] OFF_TSTAT  = 3'd4;
  localparam logic [2:0] OFF_UTX    = 3'd5;
  localparam logic [2:0] OFF_USTAT  = 3'd6;

  localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_bridge_if.sv
// MEM-stage data bus between the CPU core (master) and the bridge (slave).
interface data_bus_bridge_if;

  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output ce_i, we_i, addr_i, sel_i, wdata_i, input rdata_o);
  modport slave  (input ce_i, we_i, addr_i, sel_i, wdata_i, output rdata_o);

endinterface

// File: rtl/data_bus_bridge_uart_tx.sv
// 8N1 UART transmitter; a start pulse is taken only while idle, each bit lasts CLK_DIV cycles.
module data_bus_bridge_uart_tx
  import data_bus_bridge_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             busy_r;
  logic             bit_done_s;

  assign bit_done_s = (cnt_r == CNT_LAST);

  // State, baud counter, shifter and line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= UART_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != UART_IDLE);
    end
  end

  // Next-state logic; tx_s is the line level for the coming cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    case (state_r)
      UART_IDLE: begin
        if (start) begin
          state_s = UART_START;
          cnt_s   = CNT_ZERO;
          shift_s = data;
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      UART_START: begin
        if (bit_done_s) begin
          state_s = UART_DATA;
          cnt_s   = CNT_ZERO;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      UART_DATA: begin
        if (bit_done_s) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 3'd7) begin
            state_s = UART_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      UART_STOP: begin
        if (bit_done_s) begin
          state_s = UART_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = UART_IDLE;
        cnt_s   = CNT_ZERO;
        tx_s    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: rtl/data_bus_bridge.sv
// Zero-wait-state data bridge: byte-lane RAM plus MMIO (LED, switches, timer, UART TX).
// Define BRIDGE_TIMER_EN to build the compare timer (TCOUNT/TCMP/TSTAT, timer_irq_o).
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 12,
  parameter int         CLK_DIV    = 868,
  parameter logic [3:0] MMIO_NIB   = 4'h1
) (
  input  logic                clk,
  input  logic                rst,
  data_bus_bridge_if.slave    bus,
  input  logic [15:0]         sw_i,
  output logic [15:0]         led_o,
  output logic                uart_tx_o,
  output logic                timer_irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [2:0]            off_s;
  logic                  ram_hit_s, mmio_hit_s, rd_s, wr_s;
  logic                  ram_wr_s, mmio_wr_s, utx_start_s, uart_busy_s;
  logic [15:0]           led_r, sw_meta_r, sw_sync_r;
  logic [31:0]           tcount_rd_s, tcmp_rd_s, tstat_rd_s, rdata_s;
  logic                  unused_s;

  assign idx_s       = bus.addr_i[DEPTH_LOG2+1:2];
  assign off_s       = bus.addr_i[4:2];
  assign ram_hit_s   = (bus.addr_i[31:28] == REGION_RAM);
  assign mmio_hit_s  = (bus.addr_i[31:28] == MMIO_NIB);
  assign rd_s        = bus.ce_i & ~bus.we_i;
  assign wr_s        = bus.ce_i & bus.we_i;
  assign ram_wr_s    = wr_s & ram_hit_s;
  assign mmio_wr_s   = wr_s & mmio_hit_s;
  assign utx_start_s = mmio_wr_s & (off_s == OFF_UTX);
  assign unused_s    = ^{bus.addr_i[27:DEPTH_LOG2+2], bus.addr_i[1:0]};

  // Data RAM with byte lanes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      mem_r[idx_s] <= lane_merge(mem_r[idx_s], bus.wdata_i, bus.sel_i);
    end
  end

  // LED register and two-flop switch synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r     <= 16'h0000;
      sw_meta_r <= 16'h0000;
      sw_sync_r <= 16'h0000;
    end else begin
      if (mmio_wr_s && (off_s == OFF_LED)) begin
        led_r <= bus.wdata_i[15:0];
      end
      sw_meta_r <= sw_i;
      sw_sync_r <= sw_meta_r;
    end
  end

`ifdef BRIDGE_TIMER_EN
  logic [31:0] tcount_r, tcmp_r;
  logic        irq_r, match_s, tstat_clr_s;

  assign match_s     = (tcount_r == tcmp_r);
  assign tstat_clr_s = mmio_wr_s & (off_s == OFF_TSTAT) & bus.wdata_i[0];

  // Free-running counter, compare value and sticky match flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      tcount_r <= 32'h0000_0000;
      tcmp_r   <= TCMP_RESET;
      irq_r    <= 1'b0;
    end else begin
      if (mmio_wr_s && (off_s == OFF_TCOUNT)) begin
        tcount_r <= bus.wdata_i;
      end else begin
        tcount_r <= tcount_r + 32'd1;
      end
      if (mmio_wr_s && (off_s == OFF_TCMP)) begin
        tcmp_r <= bus.wdata_i;
      end
      if (match_s) begin
        irq_r <= 1'b1;
      end else if (tstat_clr_s) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign tcount_rd_s = tcount_r;
  assign tcmp_rd_s   = tcmp_r;
  assign tstat_rd_s  = {31'h0000_0000, irq_r};
  assign timer_irq_o = irq_r;
`else
  assign tcount_rd_s = 32'h0000_0000;
  assign tcmp_rd_s   = 32'h0000_0000;
  assign tstat_rd_s  = 32'h0000_0000;
  assign timer_irq_o = 1'b0;
`endif

  data_bus_bridge_uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .start (utx_start_s),
    .data  (bus.wdata_i[7:0]),
    .tx    (uart_tx_o),
    .busy  (uart_busy_s)
  );

  // Same-cycle read mux; the core has no stall path, so this stays combinational.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (rd_s && ram_hit_s) begin
      rdata_s = mem_r[idx_s];
    end else if (rd_s && mmio_hit_s) begin
      case (off_s)
        OFF_LED:    rdata_s = {16'h0000, led_r};
        OFF_SW:     rdata_s = {16'h0000, sw_sync_r};
        OFF_TCOUNT: rdata_s = tcount_rd_s;
        OFF_TCMP:   rdata_s = tcmp_rd_s;
        OFF_TSTAT:  rdata_s = tstat_rd_s;
        OFF_UTX:    rdata_s = 32'h0000_0000;
        OFF_USTAT:  rdata_s = {31'h0000_0000, uart_busy_s};
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.rdata_o = rdata_s;
  assign led_o       = led_r;

endmodule
